// File: rtl/svm_cascade_stage.sv
// svm_cascade_stage: serial linear-kernel SVM decision engine for one cascade stage.
// Optional macro SVM_ACC_SAT_EN: saturating MAC/BIAS additions instead of two's-complement wrap.
module svm_cascade_stage #(
    parameter int XLEN_PIXEL    = 8,
    parameter int NUM_OF_PIXELS = 4,
    parameter int NUM_OF_SV     = 10,
    parameter int XLEN_ALPHA    = 16,
    parameter int ACC_W         = 40,
    parameter int MARGIN        = 256,
    localparam int CFG_AW = $clog2(NUM_OF_SV*NUM_OF_PIXELS+NUM_OF_SV+1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic                                  cfg_we,
    input  logic [CFG_AW-1:0]                     cfg_addr,
    input  logic [ACC_W-1:0]                      cfg_wdata,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_OF_PIXELS*XLEN_PIXEL-1:0]   in_pixel,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  y_class,
    output logic                                  y_forward,
    output logic [ACC_W-1:0]                      y_score,
    output logic [2:0]                            dbg_state
);
    // Both streams use valid/ready: a transfer happens on the rising clk edge where
    // valid, ready and en are all high; the source holds valid and data until then.

    localparam int NSV_NPIX = NUM_OF_SV * NUM_OF_PIXELS;
    localparam int SV_AW    = (NSV_NPIX > 1) ? $clog2(NSV_NPIX) : 1;
    localparam int J_W      = (NUM_OF_SV > 1) ? $clog2(NUM_OF_SV) : 1;
    localparam int K_W      = 2*XLEN_PIXEL + $clog2(NUM_OF_PIXELS);
    localparam int PROD_W   = XLEN_ALPHA + K_W + 1;
    localparam int SUM_W    = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;
`ifdef SVM_ACC_SAT_EN
    localparam int MW = SUM_W;
`else
    localparam int MW = ACC_W;
`endif
    localparam logic signed [ACC_W-1:0] MARGIN_S = ACC_W'(MARGIN);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DOT  = 3'd1,
        S_MAC  = 3'd2,
        S_BIAS = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                                r_state;
    logic [J_W-1:0]                        r_j;
    logic [K_W-1:0]                        r_k;
    logic signed [ACC_W-1:0]               r_acc;
    logic [NUM_OF_PIXELS*XLEN_PIXEL-1:0]   r_x;
    logic                                  r_out_valid;
    logic                                  r_y_class;
    logic                                  r_y_forward;
    logic [ACC_W-1:0]                      r_y_score;

    logic [XLEN_PIXEL-1:0]                 r_sv    [NSV_NPIX];
    logic signed [XLEN_ALPHA-1:0]          r_alpha [NUM_OF_SV];
    logic signed [ACC_W-1:0]               r_bias;

    logic [K_W-1:0]                        w_dot;
    logic signed [MW-1:0]                  w_prod;
    logic signed [MW-1:0]                  w_addend;
    logic signed [MW-1:0]                  w_sum;
    logic signed [ACC_W-1:0]               w_acc_nxt;
    logic                                  w_fwd;
    logic [SV_AW-1:0]                      w_sv_widx;
    logic [J_W-1:0]                        w_alpha_widx;

    always_comb begin
        w_dot = '0;
        for (int i = 0; i < NUM_OF_PIXELS; i++) begin
            w_dot = w_dot + K_W'(r_x[i*XLEN_PIXEL +: XLEN_PIXEL])
                          * K_W'(r_sv[SV_AW'(int'(r_j)*NUM_OF_PIXELS + i)]);
        end
    end

    // Product is formed at the adder width so the saturating build sees the exact value.
    assign w_prod   = MW'(r_alpha[r_j]) * $signed(MW'(r_k));
    assign w_addend = (r_state == S_BIAS) ? MW'(r_bias) : w_prod;
    assign w_sum    = MW'(r_acc) + w_addend;

`ifdef SVM_ACC_SAT_EN
    always_comb begin
        w_acc_nxt = w_sum[ACC_W-1:0];
        if (!((&w_sum[MW-1:ACC_W-1]) || !(|w_sum[MW-1:ACC_W-1]))) begin
            w_acc_nxt = w_sum[MW-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign w_acc_nxt = w_sum;
`endif

    // Most-negative acc can never exceed -MARGIN, so it is never forwarded.
    assign w_fwd = (r_acc < MARGIN_S) && (r_acc > -MARGIN_S);

    assign w_sv_widx    = SV_AW'(cfg_addr);
    assign w_alpha_widx = J_W'(cfg_addr - CFG_AW'(NSV_NPIX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSV_NPIX; i++) r_sv[i] <= '0;
            for (int i = 0; i < NUM_OF_SV; i++) r_alpha[i] <= '0;
            r_bias <= '0;
        end else if (cfg_we && (r_state == S_IDLE)) begin
            if (cfg_addr < CFG_AW'(NSV_NPIX)) begin
                r_sv[w_sv_widx] <= cfg_wdata[XLEN_PIXEL-1:0];
            end else if (cfg_addr < CFG_AW'(NSV_NPIX + NUM_OF_SV)) begin
                r_alpha[w_alpha_widx] <= cfg_wdata[XLEN_ALPHA-1:0];
            end else if (cfg_addr == CFG_AW'(NSV_NPIX + NUM_OF_SV)) begin
                r_bias <= cfg_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_j         <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_x         <= '0;
            r_out_valid <= 1'b0;
            r_y_class   <= 1'b0;
            r_y_forward <= 1'b0;
            r_y_score   <= '0;
        end else if (en) begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x     <= in_pixel;
                        r_acc   <= '0;
                        r_j     <= '0;
                        r_state <= S_DOT;
                    end
                end
                S_DOT: begin
                    r_k     <= w_dot;
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    r_acc <= w_acc_nxt;
                    if (r_j == J_W'(NUM_OF_SV - 1)) begin
                        r_state <= S_BIAS;
                    end else begin
                        r_j     <= r_j + J_W'(1);
                        r_state <= S_DOT;
                    end
                end
                S_BIAS: begin
                    r_acc   <= w_acc_nxt;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    // First DONE cycle publishes the result; later cycles wait for the sink.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_y_score   <= r_acc;
                        r_y_class   <= ~r_acc[ACC_W-1];
                        r_y_forward <= w_fwd;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE) && en;
    assign out_valid = r_out_valid;
    assign y_class   = r_y_class;
    assign y_forward = r_y_forward;
    assign y_score   = r_y_score;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_svm_cascade_stage.sv
// Self-checking bench for svm_cascade_stage: default-size instance plus a 24-bit accumulator instance.
module tb_svm_cascade_stage;
    localparam int XP     = 8;
    localparam int NP     = 4;
    localparam int NSV    = 10;
    localparam int AW     = 40;
    localparam int MARGIN = 256;
    localparam int CFG_AW = $clog2(NSV*NP+NSV+1);
    localparam int A_ALPHA = NSV*NP;
    localparam int A_BIAS  = NSV*NP + NSV;
`ifdef SVM_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              en, cfg_we, cfg_we2, in_valid, in_valid2, out_ready, out_ready2;
    logic [CFG_AW-1:0] cfg_addr;
    logic [AW-1:0]     cfg_wdata;
    logic [NP*XP-1:0]  in_pixel;
    logic              in_ready, out_valid, y_class, y_forward;
    logic [AW-1:0]     y_score;
    logic [2:0]        dbg_state;
    logic              in_ready2, out_valid2, y_class2, y_forward2;
    logic [23:0]       y_score2;
    logic [2:0]        dbg_state2;

    svm_cascade_stage dut (
        .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .in_valid(in_valid), .in_ready(in_ready),
        .in_pixel(in_pixel), .out_valid(out_valid), .out_ready(out_ready),
        .y_class(y_class), .y_forward(y_forward), .y_score(y_score), .dbg_state(dbg_state)
    );

    svm_cascade_stage #(.ACC_W(24)) dut24 (
        .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we2), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata[23:0]), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_pixel(in_pixel), .out_valid(out_valid2), .out_ready(out_ready2),
        .y_class(y_class2), .y_forward(y_forward2), .y_score(y_score2), .dbg_state(dbg_state2)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]         m_sv    [NSV*NP];
    logic signed [15:0] m_alpha [NSV];
    longint             m_bias;

    task automatic model_clear();
        for (int i = 0; i < NSV*NP; i++) m_sv[i] = '0;
        for (int i = 0; i < NSV; i++) m_alpha[i] = '0;
        m_bias = 0;
    endtask

    function automatic longint add_w(input longint a, input longint b, input int w, input bit sat);
        longint s, mx, mn;
        s  = a + b;
        mx = (longint'(1) <<< (w-1)) - 1;
        mn = -mx - 1;
        if (sat) begin
            if (s > mx) s = mx;
            else if (s < mn) s = mn;
        end else begin
            s = (s <<< (64-w)) >>> (64-w);
        end
        return s;
    endfunction

    function automatic logic [AW+1:0] model(input logic [NP*XP-1:0] px);
        longint acc, k;
        acc = 0;
        for (int j = 0; j < NSV; j++) begin
            k = 0;
            for (int i = 0; i < NP; i++) k += longint'(px[i*XP +: XP]) * longint'(m_sv[j*NP+i]);
            acc = add_w(acc, longint'(m_alpha[j]) * k, AW, SAT);
        end
        acc = add_w(acc, m_bias, AW, SAT);
        return {(acc >= 0), ((acc < MARGIN) && (acc > -MARGIN)), acc[AW-1:0]};
    endfunction

    // ---------------- scoreboard ----------------
    logic [AW+1:0] exp_q[$];
    logic [AW+1:0] sb_e;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && en) begin
            if (exp_q.size() == 0) begin
                check_val("sb_unexpected_out", 1, 0);
            end else begin
                sb_e = exp_q.pop_front();
                check_val("sb_score", y_score, sb_e[AW-1:0]);
                check_val("sb_class", y_class, sb_e[AW+1]);
                check_val("sb_fwd", y_forward, sb_e[AW]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    longint t_acc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input int addr, input longint data, input bit upd);
        cfg_addr  = CFG_AW'(addr);
        cfg_wdata = data[AW-1:0];
        cfg_we    = 1'b1;
        tick();
        cfg_we    = 1'b0;
        if (upd) begin
            if (addr < NSV*NP) m_sv[addr] = data[7:0];
            else if (addr < A_BIAS) m_alpha[addr-A_ALPHA] = data[15:0];
            else if (addr == A_BIAS) m_bias = (data <<< (64-AW)) >>> (64-AW);
        end
    endtask

    task automatic cfg_wr24(input int addr, input longint data);
        cfg_addr  = CFG_AW'(addr);
        cfg_wdata = data[AW-1:0];
        cfg_we2   = 1'b1;
        tick();
        cfg_we2   = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) check_val("idle_timeout", 0, 1);
    endtask

    task automatic send(input logic [NP*XP-1:0] px);
        in_pixel = px;
        in_valid = 1'b1;
        wait_idle();
        @(posedge clk);
        #1;
        t_acc    = cyc;
        in_valid = 1'b0;
        exp_q.push_back(model(px));
    endtask

    task automatic wait_out(input longint exp_lat, input string tag);
        while (!out_valid && (cyc - t_acc) < 200) tick();
        check_val(tag, cyc - t_acc, exp_lat);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [AW-1:0]    exp_s;
    logic [AW+1:0]    e4;
    logic [NP*XP-1:0] rp;
    logic signed [15:0] ra;
    logic signed [31:0] rb;
    longint           s24;

    initial begin
        rst = 1'b1; en = 1'b1; cfg_we = 1'b0; cfg_we2 = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        in_valid = 1'b0; in_valid2 = 1'b0; in_pixel = '0; out_ready = 1'b1; out_ready2 = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_score", y_score, 0);
        check_val("rst_state", dbg_state, 0);
        check_val("rst_state24", dbg_state2, 0);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_in_ready", in_ready, 1);
        tick();

        // Large negative score from saturated pixels
        for (int i = 0; i < NP; i++) cfg_wr(i, 255, 1'b1);
        cfg_wr(A_ALPHA, -100, 1'b1);
        send('1);
        wait_out(22, "lat_big_neg");
        exp_s = -26010000;
        check_val("big_neg_score", y_score, exp_s);
        check_val("big_neg_class", y_class, 0);

        // Zero score with non-zero bias
        wait_idle();
        for (int i = 0; i < NP; i++) cfg_wr(i, i + 1, 1'b1);
        cfg_wr(A_ALPHA, 1, 1'b1);
        cfg_wr(A_BIAS, -10, 1'b1);
        send(32'h01010101);
        wait_out(22, "lat_zero");
        check_val("zero_class", y_class, 1);
        check_val("zero_fwd", y_forward, 1);

        wait_idle();
        cfg_wr(A_BIAS, -5, 1'b1);
        send(32'h01010101);
        wait_out(22, "lat_five");

        // Asynchronous reset while in DOT
        send(32'h01010101);
        #1 rst = 1'b1;
        #1;
        check_val("arst_out_valid", out_valid, 0);
        check_val("arst_score", y_score, 0);
        check_val("arst_class", y_class, 0);
        check_val("arst_fwd", y_forward, 0);
        exp_q.delete();
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_val("post_rst_ready", in_ready, 1);
        send(32'h01010101);
        wait_out(22, "lat_cleared");

        // Two active SVs, then output backpressure with an ignored config write
        wait_idle();
        for (int i = 0; i < NP; i++) cfg_wr(i, i + 1, 1'b1);
        for (int i = 0; i < NP; i++) cfg_wr((NSV-1)*NP + i, 10*(i + 1), 1'b1);
        cfg_wr(A_ALPHA, 3, 1'b1);
        cfg_wr(A_ALPHA + NSV - 1, -2, 1'b1);
        cfg_wr(A_BIAS, 7, 1'b1);
        out_ready = 1'b0;
        e4 = model(32'h08070605);
        send(32'h08070605);
        wait_out(22, "lat_hold");
        cfg_wr(A_ALPHA, 99, 1'b0);
        for (int n = 0; n < 5; n++) begin
            if (n > 0) tick();
            check_val("hold_valid", out_valid, 1);
            check_val("hold_score", y_score, e4[AW-1:0]);
            check_val("hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("ready_after_hs", in_ready, 1);
        send(32'h08070605);
        wait_out(22, "lat_rerun");
        check_val("rerun_score", y_score, e4[AW-1:0]);

        // Enable dropped for 3 cycles while in MAC
        send(32'h01010101);
        tick();
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        wait_out(25, "lat_en_stall");

        // Random configurations and vectors
        for (int n = 0; n < 4; n++) begin
            wait_idle();
            for (int m = 0; m < 6; m++) cfg_wr($urandom_range(0, NSV*NP-1), $urandom_range(0, 255), 1'b1);
            ra = 16'($urandom_range(0, 65535));
            cfg_wr(A_ALPHA + $urandom_range(0, NSV-1), longint'(ra), 1'b1);
            rb = $urandom;
            cfg_wr(A_BIAS, longint'(rb), 1'b1);
            rp = $urandom;
            send(rp);
            wait_out(22, "lat_rand");
        end
        wait_idle();

        // 24-bit accumulator overflow
        for (int i = 0; i < NP; i++) cfg_wr24(i, 255);
        cfg_wr24(A_ALPHA, 32767);
        in_pixel  = '1;
        in_valid2 = 1'b1;
        @(negedge clk);
        check_val("acc24_ready", in_ready2, 1);
        @(posedge clk);
        #1;
        t_acc     = cyc;
        in_valid2 = 1'b0;
        while (!out_valid2 && (cyc - t_acc) < 200) tick();
        check_val("lat_acc24", cyc - t_acc, 22);
        s24 = add_w(0, longint'(32767) * longint'(260100), 24, SAT);
        s24 = add_w(s24, 0, 24, SAT);
        check_val("acc24_score", y_score2, s24[23:0]);
        check_val("acc24_class", y_class2, s24 >= 0);
        check_val("acc24_fwd", y_forward2, (s24 < MARGIN) && (s24 > -MARGIN));

        repeat (3) tick();
        check_val("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/svm_cascade_stage.md
Name: svm_cascade_stage

Overview:
Parametrised linear-kernel SVM decision engine for one stage of the cascaded classifier. Generalises the fixed-size stage-1 top.
- Support vectors, alphas and bias are loaded through a config write port.
- Feature vectors arrive over a valid/ready stream.
- Evaluates f(x) = sum_j alpha_j*(x·sv_j) + bias serially over the SVs.
- Emits the class, the signed score, and a forward flag that routes low-margin samples to the next cascade stage.

Parameters:
XLEN_PIXEL, 8, unsigned pixel width
NUM_OF_PIXELS, 4, pixels per feature vector
NUM_OF_SV, 10, number of support vectors
XLEN_ALPHA, 16, signed alpha width
ACC_W, 40, signed accumulator/score width; also cfg_wdata width
MARGIN, 256, |score| < MARGIN asserts y_forward
(localparam CFG_AW = $clog2(NUM_OF_SV*NUM_OF_PIXELS+NUM_OF_SV+1))

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
en  in  1  global enable; low freezes FSM and datapath
cfg_we  in  1  config write strobe
cfg_addr  in  CFG_AW  config address
cfg_wdata  in  ACC_W  config data
in_valid  in  1  feature vector valid
in_ready  out  1  engine can accept a vector
in_pixel  in  NUM_OF_PIXELS*XLEN_PIXEL  pixel i at bits [i*XLEN_PIXEL +: XLEN_PIXEL]
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
y_class  out  1  1 when score >= 0
y_forward  out  1  1 when |score| < MARGIN
y_score  out  ACC_W  signed decision value

Behaviour:
- Reset (async, any state): FSM to IDLE; all SV/alpha/bias storage cleared to 0; accumulator cleared; out_valid, y_class, y_forward, y_score = 0.
- Config address map:
  - addr < NSV*NPIX: SV j pixel i at addr j*NPIX+i, stores low XLEN_PIXEL bits.
  - next NSV addresses: alpha j, stores low XLEN_ALPHA bits as signed.
  - next address: bias, full ACC_W, signed.
  - Out-of-range addresses ignored. Writes take effect only in IDLE; ignored in all other states.
- in_ready = (state==IDLE) & en. Accept on in_valid & in_ready: latch pixels, clear acc, j=0, go DOT.
- FSM:
  - DOT: K = sum_i x_i*sv_j,i, unsigned, 2*XLEN_PIXEL+clog2(NPIX) bits, registered; go MAC.
  - MAC: acc += sext(alpha_j)*K (signed product, sign-extended to ACC_W). If j==NSV-1 go BIAS, else j++ and go DOT.
  - BIAS: acc += bias; go DONE.
  - DONE: out_valid=1; y_score=acc; y_class=~acc[ACC_W-1]; y_forward=(|acc|<MARGIN), with |most-negative| treated as not < MARGIN. Hold until out_valid & out_ready, then go IDLE.
- Latency: out_valid rises 2*NUM_OF_SV+2 cycles after the accept edge (22 at defaults) with en held high.
- en low: state, j, K, acc all hold; in_ready=0; DONE outputs stay stable, and the output handshake does not complete until en returns high.
- Next input accepted at the earliest one cycle after the output handshake (IDLE cycle).
- Outputs y_* remain at their last values outside DONE.
- Arithmetic wraps two's-complement at ACC_W unless the optional feature is enabled.

Optional Feature:
- Macro SVM_ACC_SAT_EN.
- Defined: each MAC and BIAS addition saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- Undefined: additions wrap modulo 2^ACC_W.

Test Plan:
1. Assert rst mid-DOT with en=1 → immediately out_valid=0, y_score=0, y_class=0, y_forward=0; after release, in_ready=1 next cycle and all config reads back 0 (all-zero SVs give score 0, y_class=1).
2. Program sv0={1,2,3,4}, alpha0=1, other alphas 0, bias=-10; send x={1,1,1,1} → score 0, y_class=1, y_forward=1, out_valid exactly 22 cycles after accept.
3. sv0 and x all 255, alpha0=-100, bias=0 → K=260100, score=-26010000, y_class=0, y_forward=0.
4. Hold out_ready low 5 cycles in DONE and issue a cfg write to alpha0 meanwhile → out_valid and y_score stable, in_ready=0, write ignored (a rerun gives the same score); after handshake, in_ready=1 the following cycle.
5. Drop en for 3 cycles during MAC → out_valid appears exactly 3 cycles later than the 22-cycle baseline, with the same score.
6. ACC_W=24, alpha0=32767, sv0 and x all 255 → score 8388607 with SVM_ACC_SAT_EN; (32767*260100) mod 2^24 as signed without it.
